// File: rtl/axi4_arb_pkg.sv
// Shared constants for the AXI4 requester-port arbiter.
// State codes, response codes and the fixed protection value.
package axi4_arb_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE  = 3'd0;
   localparam state_t WADDR = 3'd1;
   localparam state_t WRESP = 3'd2;
   localparam state_t RADDR = 3'd3;
   localparam state_t RDATA = 3'd4;
   localparam state_t ACK   = 3'd5;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam logic [2:0] PROT_DEFAULT  = 3'b000;

endpackage

// File: rtl/axi4_port_arbiter_rr.sv
// Combinational round-robin pick: first requester after the
// most recent winner, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last,
   output logic [$clog2(NREQ)-1:0] gnt_idx,
   output logic                    any
);

   localparam int IW = $clog2(NREQ);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IW'((int'(last) + k) % NREQ);
         if (!found && req[idx]) begin
            gnt_idx = idx;
            found   = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/axi4_port_arbiter.sv
// Round-robin share of one single-beat AXI4 master port between
// NREQ simple requesters; one transaction outstanding at a time.
module axi4_port_arbiter
   import axi4_arb_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int ADDRWIDTH = 32,
   parameter int DATAWIDTH = 32
) (
   input  logic                      clk,
   input  logic                      nreset,
   input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
   input  logic [NREQ*DATAWIDTH-1:0] req_wdata,
   input  logic [NREQ-1:0]           req_we,
   input  logic [NREQ-1:0]           req_rd,
   output logic [NREQ-1:0]           req_ack,
   output logic [NREQ-1:0]           req_err,
   output logic [DATAWIDTH-1:0]      req_rdata,
   output logic [ADDRWIDTH-1:0]      awaddr,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [2:0]                awprot,
   output logic [DATAWIDTH-1:0]      wdata,
   output logic                      wvalid,
   input  logic                      wready,
   output logic                      wlast,
   input  logic                      bvalid,
   output logic                      bready,
   input  logic [1:0]                bresp,
   output logic [ADDRWIDTH-1:0]      araddr,
   output logic                      arvalid,
   input  logic                      arready,
   output logic [2:0]                arprot,
   input  logic [DATAWIDTH-1:0]      rdata,
   input  logic                      rvalid,
   output logic                      rready,
   input  logic [1:0]                rresp
);

   localparam int IW = $clog2(NREQ);

   state_t               state, nstate;
   logic [NREQ-1:0]      req;
   logic [IW-1:0]        last, g, pick;
   logic                 any;
   logic [ADDRWIDTH-1:0] addr_q;
   logic [DATAWIDTH-1:0] wdata_q;
   logic                 err_q, aw_done, w_done;
   logic                 aw_hs, w_hs, b_hs, r_hs;

   assign req   = req_we | req_rd;
   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;
   assign b_hs  = bvalid & bready;
   assign r_hs  = rvalid & rready;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req     (req),
      .last    (last),
      .gnt_idx (pick),
      .any     (any)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:
            if (any) nstate = req_we[pick] ? WADDR : RADDR;
         WADDR:
            if ((aw_done | aw_hs) & (w_done | w_hs))
               nstate = WRESP;
         WRESP: if (b_hs) nstate = ACK;
         RADDR: if (arvalid & arready) nstate = RDATA;
         RDATA: if (r_hs) nstate = ACK;
         ACK:   nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Transaction latches; the state itself records the direction.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         last      <= IW'(NREQ - 1);
         g         <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         req_rdata <= '0;
      end else begin
         if (state == IDLE && any) begin
            g       <= pick;
            last    <= pick;
            addr_q  <= req_addr[pick*ADDRWIDTH +: ADDRWIDTH];
            wdata_q <= req_wdata[pick*DATAWIDTH +: DATAWIDTH];
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
         if (b_hs)  err_q   <= (bresp != AXI_RESP_OKAY);
         if (r_hs) begin
            req_rdata <= rdata;
            err_q     <= (rresp != AXI_RESP_OKAY);
         end
      end
   end

   always_comb begin
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b0;
      arvalid = 1'b0;
      rready  = 1'b0;
      req_ack = '0;
      req_err = '0;
      unique case (state)
         WADDR: begin
            awvalid = ~aw_done;
            wvalid  = ~w_done;
         end
         WRESP: bready  = 1'b1;
         RADDR: arvalid = 1'b1;
         RDATA: rready  = 1'b1;
         ACK: begin
            req_ack[g] = 1'b1;
            req_err[g] = err_q;
         end
         default: ;
      endcase
   end

   assign awaddr = awvalid ? addr_q  : 'x;
   assign araddr = arvalid ? addr_q  : 'x;
   assign wdata  = wvalid  ? wdata_q : 'x;
   assign wlast  = wvalid;
   assign awprot = PROT_DEFAULT;
   assign arprot = PROT_DEFAULT;

endmodule

// File: tb/tb_axi4_port_arbiter.sv
// Directed bench for axi4_port_arbiter (NREQ=3) with a small
// AXI slave driven from tasks on the falling clock edge.
module tb_axi4_port_arbiter;

   logic        clk = 1'b0;
   logic        nreset;
   logic [95:0] req_addr;
   logic [95:0] req_wdata;
   logic [2:0]  req_we, req_rd, req_ack, req_err;
   logic [31:0] req_rdata;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic        awvalid, awready, wvalid, wready, wlast;
   logic        bvalid, bready, arvalid, arready;
   logic        rvalid, rready;
   logic [2:0]  awprot, arprot;
   logic [1:0]  bresp, rresp;

   int n_cmp = 0;
   int n_bad = 0;
   int overlap = 0;
   int lastbad = 0;

   int          ap, aw_n, w_n;
   logic        ev;
   logic [31:0] rv, ag, dg;
   bit          seen;

   always #5 clk = ~clk;

   axi4_port_arbiter #(
      .NREQ(3), .ADDRWIDTH(32), .DATAWIDTH(32)
   ) dut (
      .clk(clk), .nreset(nreset),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_we(req_we), .req_rd(req_rd),
      .req_ack(req_ack), .req_err(req_err),
      .req_rdata(req_rdata),
      .awaddr(awaddr), .awvalid(awvalid),
      .awready(awready), .awprot(awprot),
      .wdata(wdata), .wvalid(wvalid),
      .wready(wready), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .araddr(araddr), .arvalid(arvalid),
      .arready(arready), .arprot(arprot),
      .rdata(rdata), .rvalid(rvalid),
      .rready(rready), .rresp(rresp)
   );

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic slave_idle();
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rresp = 0; rdata = 0;
   endtask

   // Runs one transaction to its ack; readies follow the given
   // waits, counted in cycles of the matching valid/ready.
   task automatic serve(input int aw_dly, input int w_dly,
                        input int r_dly, input logic [1:0] resp,
                        input logic [31:0] rdat,
                        output int ackp, output logic errv,
                        output logic [31:0] rdv,
                        output logic [31:0] a_got,
                        output logic [31:0] d_got,
                        output int an, output int wn);
      int  aw_w, w_w, r_w, cyc;
      bit  done;
      aw_w = 0; w_w = 0; r_w = 0; cyc = 0; done = 0;
      ackp = -1; errv = 0; rdv = 0; a_got = 0; d_got = 0;
      an = 0; wn = 0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         slave_idle();
         if (awvalid && arvalid) overlap++;
         if (|req_ack) begin
            check("ack_onehot", 64'($countones(req_ack)), 1);
            check("err_stray", 64'(req_err & ~req_ack), 0);
            for (int i = 0; i < 3; i++) begin
               if (req_ack[i]) begin
                  ackp = i;
                  errv = req_err[i];
                  req_we[i] = 1'b0;
                  req_rd[i] = 1'b0;
               end
            end
            rdv  = req_rdata;
            done = 1;
         end else begin
            if (awvalid) begin
               if (aw_w == aw_dly) begin
                  awready = 1; an++; a_got = awaddr;
               end else aw_w++;
            end
            if (wvalid) begin
               if (w_w == w_dly) begin
                  wready = 1; wn++; d_got = wdata;
                  if (!wlast) lastbad++;
               end else w_w++;
            end
            if (arvalid) begin
               if (aw_w == aw_dly) begin
                  arready = 1; a_got = araddr;
               end else aw_w++;
            end
            if (bready) begin
               if (r_w == r_dly) begin
                  bvalid = 1; bresp = resp;
               end else r_w++;
            end
            if (rready) begin
               if (r_w == r_dly) begin
                  rvalid = 1; rresp = resp; rdata = rdat;
               end else r_w++;
            end
         end
      end
      if (!done) check("timeout", 0, 1);
   endtask

   initial begin
      // 1: reset with arbitrary inputs
      nreset = 0;
      req_addr = {96{1'b1}};
      req_wdata = {3{32'hCAFE_F00D}};
      req_we = 3'b101; req_rd = 3'b011;
      awready = 1; wready = 1; bvalid = 1; bresp = 2'b11;
      arready = 1; rvalid = 1; rresp = 2'b10;
      rdata = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      check("rst_valids",
            64'({awvalid, wvalid, arvalid, bready, rready}), 0);
      check("rst_ack", 64'(req_ack), 0);
      check("rst_err", 64'(req_err), 0);
      check("rst_rdata", 64'(req_rdata), 0);
      check("prot", 64'({awprot, arprot}), 0);
      req_we = 0; req_rd = 0; slave_idle();
      @(negedge clk);
      nreset = 1;
      repeat (3) @(negedge clk);
      check("idle_valids",
            64'({awvalid, wvalid, arvalid, bready, rready}), 0);
      check("idle_ack", 64'(req_ack), 0);

      // 2: write from port 0, awready two cycles before wready
      req_addr[0 +: 32]  = 32'h0000_1000;
      req_wdata[0 +: 32] = 32'hDEAD_BEEF;
      req_we[0] = 1;
      serve(0, 2, 0, 2'b00, 0, ap, ev, rv, ag, dg, aw_n, w_n);
      check("t2_port", 64'(ap), 0);
      check("t2_err", 64'(ev), 0);
      check("t2_awaddr", 64'(ag), 64'h1000);
      check("t2_wdata", 64'(dg), 64'hDEAD_BEEF);
      check("t2_aw_beats", 64'(aw_n), 1);
      check("t2_w_beats", 64'(w_n), 1);
      @(negedge clk);
      check("t2_ack_once", 64'(req_ack), 0);

      // 3: read from port 1 with SLVERR
      req_addr[32 +: 32] = 32'h0000_2004;
      req_rd[1] = 1;
      serve(0, 0, 0, 2'b10, 32'h1234_5678,
            ap, ev, rv, ag, dg, aw_n, w_n);
      check("t3_port", 64'(ap), 1);
      check("t3_err", 64'(ev), 1);
      check("t3_rdata", 64'(rv), 64'h1234_5678);
      check("t3_araddr", 64'(ag), 64'h2004);

      // 5: wready before awready, then both together
      @(negedge clk);
      req_addr[64 +: 32]  = 32'h0000_3000;
      req_wdata[64 +: 32] = 32'hA5A5_0001;
      req_we[2] = 1;
      serve(2, 0, 0, 2'b00, 0, ap, ev, rv, ag, dg, aw_n, w_n);
      check("t5a_port", 64'(ap), 2);
      check("t5a_aw_beats", 64'(aw_n), 1);
      check("t5a_w_beats", 64'(w_n), 1);
      check("t5a_wdata", 64'(dg), 64'hA5A5_0001);
      @(negedge clk);
      req_wdata[64 +: 32] = 32'hA5A5_0002;
      req_we[2] = 1;
      serve(0, 0, 0, 2'b01, 0, ap, ev, rv, ag, dg, aw_n, w_n);
      check("t5b_port", 64'(ap), 2);
      check("t5b_err", 64'(ev), 1);
      check("t5b_aw_beats", 64'(aw_n), 1);
      check("t5b_w_beats", 64'(w_n), 1);
      check("t5b_wdata", 64'(dg), 64'hA5A5_0002);

      // 4: all ports reading continuously, last winner was 2
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         req_addr[i*32 +: 32] = 32'h100 * (i + 1);
      req_rd = 3'b111;
      for (int t = 0; t < 6; t++) begin
         serve(0, 0, 1, 2'b00, 32'(t),
               ap, ev, rv, ag, dg, aw_n, w_n);
         check("t4_grant", 64'(ap), 64'(t % 3));
         check("t4_araddr", 64'(ag), 64'(32'h100 * (t % 3 + 1)));
         check("t4_rdata", 64'(rv), 64'(t));
         if (t == 5) begin
            req_rd = 0;
         end else begin
            @(negedge clk);
            req_rd[ap] = 1;
         end
      end
      check("t4_overlap", 64'(overlap), 0);
      check("wlast", 64'(lastbad), 0);

      // 6: reset while waiting for the write response
      @(negedge clk);
      req_addr[32 +: 32]  = 32'h0000_4000;
      req_wdata[32 +: 32] = 32'h0000_0044;
      req_we[1] = 1;
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         slave_idle();
         if (bready) seen = 1;
         else begin
            if (awvalid) awready = 1;
            if (wvalid)  wready = 1;
         end
      end
      check("t6_reach_wresp", 64'(seen), 1);
      #2 nreset = 0;
      #1;
      check("t6_async_drop",
            64'({awvalid, wvalid, arvalid, bready, rready}), 0);
      check("t6_no_ack", 64'(req_ack), 0);
      req_addr[0 +: 32] = 32'h0000_5000;
      req_rd[0] = 1;
      repeat (2) @(negedge clk);
      check("t6_ack_in_rst", 64'(req_ack), 0);
      nreset = 1;
      serve(0, 0, 0, 2'b00, 32'h77,
            ap, ev, rv, ag, dg, aw_n, w_n);
      check("t6_first_port", 64'(ap), 0);
      check("t6_araddr", 64'(ag), 64'h5000);
      check("t6_rdata", 64'(rv), 64'h77);
      serve(0, 0, 0, 2'b00, 0, ap, ev, rv, ag, dg, aw_n, w_n);
      check("t6_second_port", 64'(ap), 1);
      check("t6_awaddr", 64'(ag), 64'h4000);
      check("t6_aw_beats", 64'(aw_n), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
